// File: rtl/vu_bus_master.sv
// Vector-06C host-side VU bus cycle generator: turns single memory/I-O transfer
// requests into the full status/address/strobe sequence and samples the board's reply.
module vu_bus_master #(
    parameter int unsigned PH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_stack,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_blk,
    output logic [7:0]  vu_shap_n,
    output logic [7:0]  vu_shavv_n,
    output logic [7:0]  vu_shd_o,
    output logic        vu_shd_oe,
    input  logic [7:0]  vu_shd_i,
    output logic        vu_ras_n,
    output logic        vu_cas_n,
    output logic        vu_zpzu_n,
    output logic        vu_chtzu_n,
    output logic        vu_chtvv_n,
    output logic        vu_zpvv_n,
    output logic        vu_stack,
    output logic        vu_strob_sost,
    input  logic        vu_blk_n
);

    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] PH_M1 = CW'(PH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_STATUS, S_STHOLD, S_ASET, S_RAS, S_CSET, S_STROBE, S_RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          stack_q, stack_d;
    logic          sample_c;

    logic       ready_q, ready_d, rvalid_q, rvalid_d, rblk_q, rblk_d;
    logic [7:0] rdata_q, rdata_d, shap_q, shap_d, shavv_q, shavv_d, shd_q, shd_d;
    logic       oe_q, oe_d, ras_q, ras_d, cas_q, cas_d, zpzu_q, zpzu_d, chtzu_q, chtzu_d;
    logic       chtvv_q, chtvv_d, zpvv_q, zpvv_d, stk_q, stk_d, sost_q, sost_d;
    logic       is_io, is_wr;
    logic [7:0] psw;

    // State, phase counter and latched request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            stack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stack_q <= stack_d;
        end
    end

    // Next state, then bus outputs decoded from the state being entered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        stack_d  = stack_q;
        sample_c = 1'b0;

        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_STATUS;
                cnt_d   = PH_M1;
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                stack_d = req_stack & ~req_op[1];
            end
            S_STATUS: begin
                if (cnt_q == '0) state_d = S_STHOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_STHOLD: state_d = S_ASET;
            S_ASET: begin
                state_d = op_q[1] ? S_STROBE : S_RAS;
                cnt_d   = PH_M1;
                half_d  = 1'b0;
            end
            S_RAS: begin
                if (cnt_q == '0) state_d = S_CSET;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CSET: begin
                state_d = S_STROBE;
                cnt_d   = PH_M1;
                half_d  = 1'b0;
            end
            // Strobe is two PH halves so a 4-bit counter covers 2*PH
            S_STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!half_q) begin
                    half_d = 1'b1;
                    cnt_d  = PH_M1;
                end else begin
                    state_d  = S_RELEASE;
                    sample_c = 1'b1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        is_io = op_d[1];
        is_wr = op_d[0];
        case (op_d)
            2'b00:   psw = 8'h82;
            2'b01:   psw = 8'h00;
            2'b10:   psw = 8'h42;
            default: psw = 8'h10;
        endcase
        psw = psw | {5'b0, stack_d, 2'b0};

        ready_d  = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = (sample_c && !is_wr) ? vu_shd_i : rdata_q;
        rblk_d   = sample_c ? ~vu_blk_n : rblk_q;
        shap_d   = 8'hFF;
        shavv_d  = 8'hFF;
        shd_d    = 8'h00;
        oe_d     = 1'b0;
        ras_d    = 1'b1;
        cas_d    = 1'b1;
        zpzu_d   = 1'b1;
        chtzu_d  = 1'b1;
        chtvv_d  = 1'b1;
        zpvv_d   = 1'b1;
        stk_d    = 1'b0;
        sost_d   = 1'b0;

        case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_STATUS: begin
                oe_d = 1'b1; shd_d = psw; sost_d = 1'b1; stk_d = stack_d;
            end
            S_STHOLD: begin
                oe_d = 1'b1; shd_d = psw; stk_d = stack_d;
            end
            S_ASET: begin
                stk_d = stack_d;
                if (is_io) begin
                    shavv_d = ~addr_d[7:0];
                    if (is_wr) begin oe_d = 1'b1; shd_d = wdata_d; end
                end else begin
                    shap_d = ~addr_d[7:0];
                    if (is_wr) begin oe_d = 1'b1; shd_d = psw; end
                end
            end
            S_RAS: begin
                stk_d = stack_d; shap_d = ~addr_d[7:0]; ras_d = 1'b0;
                if (is_wr) begin oe_d = 1'b1; shd_d = psw; end
            end
            S_CSET: begin
                stk_d = stack_d; shap_d = ~addr_d[15:8]; ras_d = 1'b0;
                if (is_wr) begin oe_d = 1'b1; shd_d = wdata_d; end
            end
            S_STROBE: begin
                stk_d = stack_d;
                if (is_wr) begin oe_d = 1'b1; shd_d = wdata_d; end
                if (is_io) begin
                    shavv_d = ~addr_d[7:0];
                    if (is_wr) zpvv_d = 1'b0; else chtvv_d = 1'b0;
                end else begin
                    shap_d = ~addr_d[15:8]; ras_d = 1'b0; cas_d = 1'b0;
                    if (is_wr) zpzu_d = 1'b0; else chtzu_d = 1'b0;
                end
            end
            S_RELEASE: rvalid_d = 1'b1;
            default: ;
        endcase
    end

    // Registered bus and response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;  rvalid_q <= 1'b0;  rdata_q <= '0;  rblk_q <= 1'b0;
            shap_q  <= 8'hFF; shavv_q  <= 8'hFF; shd_q   <= '0;  oe_q   <= 1'b0;
            ras_q   <= 1'b1;  cas_q    <= 1'b1;  zpzu_q  <= 1'b1; chtzu_q <= 1'b1;
            chtvv_q <= 1'b1;  zpvv_q   <= 1'b1;  stk_q   <= 1'b0; sost_q  <= 1'b0;
        end else begin
            ready_q <= ready_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d; rblk_q <= rblk_d;
            shap_q  <= shap_d;  shavv_q  <= shavv_d;  shd_q   <= shd_d;   oe_q   <= oe_d;
            ras_q   <= ras_d;   cas_q    <= cas_d;    zpzu_q  <= zpzu_d;  chtzu_q <= chtzu_d;
            chtvv_q <= chtvv_d; zpvv_q   <= zpvv_d;   stk_q   <= stk_d;   sost_q  <= sost_d;
        end
    end

    assign req_ready     = ready_q;
    assign rsp_valid     = rvalid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_blk       = rblk_q;
    assign vu_shap_n     = shap_q;
    assign vu_shavv_n    = shavv_q;
    assign vu_shd_o      = shd_q;
    assign vu_shd_oe     = oe_q;
    assign vu_ras_n      = ras_q;
    assign vu_cas_n      = cas_q;
    assign vu_zpzu_n     = zpzu_q;
    assign vu_chtzu_n    = chtzu_q;
    assign vu_chtvv_n    = chtvv_q;
    assign vu_zpvv_n     = zpvv_q;
    assign vu_stack      = stk_q;
    assign vu_strob_sost = sost_q;

endmodule

// File: doc/vu_bus_master.md
Name: vu_bus_master

Overview:
- Vector-06C host-side bus cycle generator: the initiator end of the ВУ expansion bus that the Les Shadoks board responds to.
- Takes single-transfer requests (memory read/write, I/O in/out) and produces the full ВУ sequence: the status word on ШД with СТРОБ.СОСТ, row/column-multiplexed ~ШАП with ~RAS/~CAS, the ~ШАВВ port address, and the read/write strobes.
- Samples ШД and ~БЛК on reads and reports them back.
- Used as a bench/bring-up host model and for board-to-board loopback tests.

Parameters:
PH, 4, phase width in clk cycles; legal range 2..15.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block idle, request accepted when req_valid&req_ready
req_op  in  2  00 MEMRD, 01 MEMWR, 10 IORD, 11 IOWR
req_addr  in  16  memory address; I/O port = req_addr[7:0]
req_wdata  in  8  write data
req_stack  in  1  stack access (memory ops only)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read data (valid with rsp_valid, held until next rsp)
rsp_blk  out  1  ~БЛК was low at sample point (board claimed the cycle)
vu_shap_n  out  8  ~ШАП multiplexed address, active-low
vu_shavv_n  out  8  ~ШАВВ port address, active-low
vu_shd_o  out  8  ШД drive value
vu_shd_oe  out  1  ШД output enable
vu_shd_i  in  8  ШД sampled value
vu_ras_n, vu_cas_n  out  1 each  ~RAS, ~CAS
vu_zpzu_n, vu_chtzu_n, vu_chtvv_n, vu_zpvv_n  out  1 each  memory write/read, I/O read/write strobes
vu_stack  out  1  СТЕК
vu_strob_sost  out  1  СТРОБ.СОСТ
vu_blk_n  in  1  ~БЛК from board

Behaviour:
- Reset (async, reset_n=0) and IDLE output values:
  - all *_n strobes = 1; vu_shap_n = vu_shavv_n = 8'hFF
  - vu_strob_sost = 0, vu_stack = 0, vu_shd_oe = 0, vu_shd_o = 0
  - req_ready = 1 (IDLE only), rsp_valid = 0, rsp_rdata = 0, rsp_blk = 0
- Reset mid-cycle: outputs return to IDLE values immediately. No rsp_valid is issued for the aborted request.
- Request is latched on accept. Inputs are ignored at all other times.
- Status word (PSW), 8080 bit positions:
  - MEMRD 8'h82; MEMWR 8'h00; IORD 8'h42; IOWR 8'h10
  - bit2 is OR'd in when req_stack=1 and op is a memory op.
- Phase counter is 4 bits; each state lasts the stated clock count.
- FSM, memory ops:
  - STATUS (PH): vu_shd_oe=1, vu_shd_o=PSW, vu_strob_sost=1.
  - STHOLD (1): vu_strob_sost=0, PSW still driven.
  - ASET (1): vu_shap_n=~addr[7:0]; vu_shd_oe=0 for reads.
  - RAS (PH): vu_ras_n=0.
  - CSET (1): vu_shap_n=~addr[15:8]; for writes, vu_shd_oe=1 and vu_shd_o=wdata.
  - STROBE (2·PH): vu_cas_n=0, plus vu_chtzu_n=0 (read) or vu_zpzu_n=0 (write).
  - RELEASE (1): all strobes, vu_ras_n and vu_cas_n go to 1; vu_shap_n=FF; vu_shd_oe=0; rsp_valid=1.
  - Then IDLE.
- FSM, I/O ops: STATUS(PH) → STHOLD(1) → ASET(1, vu_shavv_n=~port) → STROBE(2·PH, vu_chtvv_n=0 or vu_zpvv_n=0; for writes ШД driven with wdata from ASET) → RELEASE(1, vu_shavv_n=FF).
- vu_stack: held high from STATUS through STROBE when the stack bit is set.
- Sampling: on the last clock of STROBE, rsp_rdata←vu_shd_i (reads only; writes leave rsp_rdata unchanged) and rsp_blk←~vu_blk_n (all ops).
- Latency, accept to rsp_valid: memory 4·PH+4 clocks; I/O 3·PH+3 clocks.
- req_ready is high the cycle after RELEASE. Back-to-back requests therefore have a 1-cycle IDLE gap.
- rsp_valid pulse never coincides with req_ready=1.
- req_valid is held while busy with no effect.
- PH<2 is illegal; the bench must not instantiate it.

Test Plan:
- Reset: reset_n=0 mid-STROBE of a MEMWR → all strobes return to 1 asynchronously, vu_shd_oe=0, no rsp_valid; after release, req_ready=1.
- MEMWR addr=16'h1234, wdata=8'hA5, PH=4 → PSW 8'h00 on ШД with strob_sost high 4 clk; vu_shap_n=8'hCB during RAS, then 8'hED; zpzu_n low 8 clk with ШД=A5; rsp_valid at clock 20.
- MEMRD addr=16'h8000, stack=1, board drives ШД=8'h3C and ~БЛК=0 → PSW 8'h86, vu_stack high; rsp_rdata=8'h3C, rsp_blk=1.
- IORD port 8'h0E, board ШД=8'h7F, ~БЛК=0 → PSW 8'h42, vu_shavv_n=8'hF1, chtvv_n low 8 clk, ras_n/cas_n stay 1; rsp_rdata=8'h7F at clock 15.
- IOWR port 8'h10, wdata=8'h23 immediately followed by MEMRD with ~БЛК=1 → PSW 8'h10; zpvv_n low with ШД=23; exactly 1 IDLE gap before the next STATUS; second rsp_blk=0.
- PH=2 MEMRD → total 12 clocks; STROBE 4 clk; STATUS 2 clk.
